// File: rtl/audio_rec_play_ctrl.sv
// rtl/audio_rec_play_ctrl.sv - sample-paced record/playback sequencer for the DDR user port
// Owns write/read pointers and recorded length; one outstanding single-word request at a time.
module audio_rec_play_ctrl #(
  parameter int unsigned       ADDR_W    = 24,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 32'h100000
) (
  input  logic              clk50M,
  input  logic              reset_n,
  input  logic              ddr_init_done,
  input  logic              record_en,
  input  logic              play_en,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] sample_in,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_out_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] rec_len,
  output logic              buf_full,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] MAX_LEN = ADDR_W'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RECORD,
    ST_PLAY
  } state_t;

  state_t state_q, state_d;

  logic [4:0]        sync_a, sync_b;
  logic              ddr_ok, rec_on, play_on, wl_s, rl_s;
  logic              wl_d, rl_d;
  logic              wl_pulse, rl_pulse;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] wr_eff, rd_eff, len_eff;
  logic              full_eff;
  logic              issue_wr, issue_rd, silence;

  // Control inputs come from a slow, unrelated clock domain.
  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
      wl_d   <= 1'b0;
      rl_d   <= 1'b0;
    end else begin
      sync_a <= {ddr_init_done, record_en, play_en, wr_load, rd_load};
      sync_b <= sync_a;
      wl_d   <= sync_b[1];
      rl_d   <= sync_b[0];
    end
  end

  assign ddr_ok  = sync_b[4];
  assign rec_on  = sync_b[3];
  assign play_on = sync_b[2];
  assign wl_s    = sync_b[1];
  assign rl_s    = sync_b[0];

  assign wl_pulse = wl_s && !wl_d && (state_q != ST_INIT);
  assign rl_pulse = rl_s && !rl_d && (state_q != ST_INIT);

  // A request issued in the same cycle as a load must already use the reloaded pointers.
  assign wr_eff   = wl_pulse ? '0 : wr_ptr;
  assign len_eff  = wl_pulse ? '0 : rec_len;
  assign full_eff = wl_pulse ? 1'b0 : buf_full;
  assign rd_eff   = rl_pulse ? '0 : rd_ptr;

  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    silence  = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (ddr_ok) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (rec_on) state_d = ST_RECORD;
        else if (play_on) state_d = ST_PLAY;
      end
      ST_RECORD: begin
        if (rec_on) begin
          if (sample_tick && !mem_req && !full_eff) issue_wr = 1'b1;
        end else if (!mem_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (play_on) begin
          if (sample_tick && !mem_req) begin
            if (rd_eff < len_eff) issue_rd = 1'b1;
            else silence = 1'b1;
          end
        end else if (!mem_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      rec_len          <= '0;
      buf_full         <= 1'b0;
      overrun          <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
    end else begin
      sample_out_valid <= 1'b0;

      if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
        if (mem_we) begin
          wr_ptr  <= wr_ptr + ONE;
          rec_len <= rec_len + ONE;
          if (rec_len + ONE == MAX_LEN) buf_full <= 1'b1;
        end else begin
          sample_out       <= mem_rdata;
          sample_out_valid <= 1'b1;
          rd_ptr           <= rd_ptr + ONE;
        end
      end

      // A tick that finds the bus busy is lost; playback repeats the held sample.
      if (sample_tick && mem_req) begin
        overrun <= 1'b1;
        if (!mem_we && state_q == ST_PLAY) sample_out_valid <= 1'b1;
      end

      if (issue_wr) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= BASE_ADDR + wr_eff;
        mem_wdata <= sample_in;
      end

      if (issue_rd) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= BASE_ADDR + rd_eff;
      end

      if (silence) begin
        sample_out       <= '0;
        sample_out_valid <= 1'b1;
      end

      if (wl_pulse) begin
        wr_ptr   <= '0;
        rec_len  <= '0;
        buf_full <= 1'b0;
      end

      if (rl_pulse) rd_ptr <= '0;
    end
  end

endmodule

// File: tb/tb_audio_rec_play_ctrl.sv
// tb/tb_audio_rec_play_ctrl.sv - directed table-driven bench for audio_rec_play_ctrl
// Instance a uses full capacity; instance b has MAX_WORDS=4 and a base that wraps the address space.
module tb_audio_rec_play_ctrl;

  localparam logic [23:0] BASE_A = 24'h000010;
  localparam logic [23:0] BASE_B = 24'hFFFFFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ddr, rec, play, wl, rl, tick;
  logic [15:0] sin;

  logic [15:0] a_sout, a_wdata, a_rdata;
  logic        a_sov, a_req, a_we, a_ack, a_full, a_ovr;
  logic [23:0] a_addr, a_len;

  logic [15:0] b_sout, b_wdata, b_rdata;
  logic        b_sov, b_req, b_we, b_ack, b_full, b_ovr;
  logic [23:0] b_addr, b_len;

  int checks = 0;
  int failures = 0;

  logic        a_hold = 1'b0;
  logic [39:0] a_wlog[$];
  logic [39:0] b_wlog[$];
  logic [15:0] a_out[$];
  logic [15:0] b_out[$];
  logic [15:0] a_mem[logic [23:0]];
  logic [15:0] b_mem[logic [23:0]];
  int          a_rd_cnt = 0;
  int          a_req_cycles = 0;
  int          b_req_cycles = 0;

  typedef struct {
    logic [15:0] din;
    logic [23:0] exp_addr;
    logic [23:0] exp_b_addr;
    logic [15:0] exp_out;
  } vec_t;

  vec_t tab[10];

  audio_rec_play_ctrl #(.ADDR_W(24), .DATA_W(16), .BASE_ADDR(BASE_A), .MAX_WORDS(32'h100000)) dut_a (
    .clk50M(clk), .reset_n(rst_n), .ddr_init_done(ddr),
    .record_en(rec), .play_en(play), .wr_load(wl), .rd_load(rl),
    .sample_tick(tick), .sample_in(sin),
    .sample_out(a_sout), .sample_out_valid(a_sov),
    .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .mem_ack(a_ack), .mem_rdata(a_rdata),
    .rec_len(a_len), .buf_full(a_full), .overrun(a_ovr)
  );

  audio_rec_play_ctrl #(.ADDR_W(24), .DATA_W(16), .BASE_ADDR(BASE_B), .MAX_WORDS(4)) dut_b (
    .clk50M(clk), .reset_n(rst_n), .ddr_init_done(ddr),
    .record_en(rec), .play_en(play), .wr_load(wl), .rd_load(rl),
    .sample_tick(tick), .sample_in(sin),
    .sample_out(b_sout), .sample_out_valid(b_sov),
    .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_ack(b_ack), .mem_rdata(b_rdata),
    .rec_len(b_len), .buf_full(b_full), .overrun(b_ovr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input logic [15:0] v);
    tick = 1'b1;
    sin  = v;
    cyc(1);
    tick = 1'b0;
    cyc(11);
  endtask

  // Memory responders: ack on the third cycle mem_req is seen high.
  initial begin : resp_a
    int w;
    w = 0;
    a_ack = 1'b0;
    a_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      a_ack = 1'b0;
      if (!rst_n) begin
        w = 0;
      end else if (a_req) begin
        a_req_cycles++;
        if (!a_hold) begin
          if (w == 2) begin
            a_ack = 1'b1;
            w = 0;
            if (a_we) begin
              a_mem[a_addr] = a_wdata;
              a_wlog.push_back({a_addr, a_wdata});
            end else begin
              a_rdata = a_mem[a_addr];
              a_rd_cnt++;
            end
          end else begin
            w++;
          end
        end
      end
      if (a_sov) a_out.push_back(a_sout);
    end
  end

  initial begin : resp_b
    int w;
    w = 0;
    b_ack = 1'b0;
    b_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      b_ack = 1'b0;
      if (!rst_n) begin
        w = 0;
      end else if (b_req) begin
        b_req_cycles++;
        if (w == 2) begin
          b_ack = 1'b1;
          w = 0;
          if (b_we) begin
            b_mem[b_addr] = b_wdata;
            b_wlog.push_back({b_addr, b_wdata});
          end else begin
            b_rdata = b_mem[b_addr];
          end
        end else begin
          w++;
        end
      end
      if (b_sov) b_out.push_back(b_sout);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [39:0] e;
    tab[0] = '{16'h0001, 24'h000010, 24'hFFFFFE, 16'h0001};
    tab[1] = '{16'h0002, 24'h000011, 24'hFFFFFF, 16'h0002};
    tab[2] = '{16'h0003, 24'h000012, 24'h000000, 16'h0003};
    tab[3] = '{16'h0004, 24'h000013, 24'h000001, 16'h0004};
    tab[4] = '{16'h0005, 24'h000014, 24'h000000, 16'h0005};
    tab[5] = '{16'h0006, 24'h000015, 24'h000000, 16'h0006};
    tab[6] = '{16'h0007, 24'h000016, 24'h000000, 16'h0007};
    tab[7] = '{16'h0008, 24'h000017, 24'h000000, 16'h0008};
    tab[8] = '{16'h0000, 24'h000000, 24'h000000, 16'h0000};
    tab[9] = '{16'h0000, 24'h000000, 24'h000000, 16'h0000};

    rst_n = 1'b0; ddr = 1'b0; rec = 1'b0; play = 1'b0;
    wl = 1'b0; rl = 1'b0; tick = 1'b0; sin = '0;
    cyc(3);
    chk("rst_sample_out", 32'(a_sout), 32'h0);
    chk("rst_sample_out_valid", 32'(a_sov), 32'h0);
    chk("rst_mem_req", 32'(a_req), 32'h0);
    chk("rst_mem_we", 32'(a_we), 32'h0);
    chk("rst_mem_addr", 32'(a_addr), 32'h0);
    chk("rst_mem_wdata", 32'(a_wdata), 32'h0);
    chk("rst_rec_len", 32'(a_len), 32'h0);
    chk("rst_buf_full", 32'(a_full), 32'h0);
    chk("rst_overrun", 32'(a_ovr), 32'h0);
    rst_n = 1'b1;
    cyc(2);

    // DDR not ready: record_en and ticks must not produce requests.
    rec = 1'b1;
    cyc(5);
    for (int i = 0; i < 10; i++) do_tick(16'h00A0 + 16'(i));
    chk("init_req_cycles_a", 32'(a_req_cycles), 32'h0);
    chk("init_req_cycles_b", 32'(b_req_cycles), 32'h0);
    chk("init_writes_a", 32'(a_wlog.size()), 32'h0);
    rec = 1'b0;
    ddr = 1'b1;
    cyc(6);

    wl = 1'b1;
    cyc(4);
    wl = 1'b0;
    cyc(2);
    rec = 1'b1;
    cyc(5);
    for (int i = 0; i < 8; i++) begin
      do_tick(tab[i].din);
      if (i == 2) chk("b_full_before_4th", 32'(b_full), 32'h0);
      if (i == 3) chk("b_full_after_4th", 32'(b_full), 32'h1);
    end
    rec = 1'b0;
    cyc(6);

    chk("rec_writes_a", 32'(a_wlog.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      e = (i < a_wlog.size()) ? a_wlog[i] : '1;
      chk($sformatf("rec_addr_a[%0d]", i), 32'(e[39:16]), 32'(tab[i].exp_addr));
      chk($sformatf("rec_data_a[%0d]", i), 32'(e[15:0]), 32'(tab[i].din));
    end
    chk("rec_len_a", 32'(a_len), 32'd8);
    chk("buf_full_a", 32'(a_full), 32'h0);
    chk("overrun_a_rec", 32'(a_ovr), 32'h0);

    chk("rec_writes_b", 32'(b_wlog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      e = (i < b_wlog.size()) ? b_wlog[i] : '1;
      chk($sformatf("rec_addr_b[%0d]", i), 32'(e[39:16]), 32'(tab[i].exp_b_addr));
      chk($sformatf("rec_data_b[%0d]", i), 32'(e[15:0]), 32'(tab[i].din));
    end
    chk("rec_len_b", 32'(b_len), 32'd4);
    chk("buf_full_b", 32'(b_full), 32'h1);
    chk("overrun_b_rec", 32'(b_ovr), 32'h0);

    // Playback of the 8 recorded words followed by silence.
    rl = 1'b1;
    cyc(4);
    rl = 1'b0;
    cyc(2);
    a_out.delete();
    b_out.delete();
    a_rd_cnt = 0;
    play = 1'b1;
    cyc(5);
    for (int i = 0; i < 10; i++) do_tick(16'h0);
    play = 1'b0;
    cyc(6);
    chk("play_out_count", 32'(a_out.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("play_out[%0d]", i), (i < a_out.size()) ? 32'(a_out[i]) : 32'hFFFF_FFFF,
          32'(tab[i].exp_out));
    end
    chk("play_reads", 32'(a_rd_cnt), 32'd8);
    chk("overrun_a_play", 32'(a_ovr), 32'h0);
    chk("play_b_out_count", 32'(b_out.size()), 32'd10);

    // Ack withheld across a tick: repeated sample, single pointer advance.
    rl = 1'b1;
    cyc(4);
    rl = 1'b0;
    cyc(2);
    a_out.delete();
    a_rd_cnt = 0;
    play = 1'b1;
    cyc(5);
    do_tick(16'h0);
    a_hold = 1'b1;
    do_tick(16'h0);
    chk("ovr_before", 32'(a_ovr), 32'h0);
    chk("ovr_req_held", 32'(a_req), 32'h1);
    do_tick(16'h0);
    chk("ovr_after", 32'(a_ovr), 32'h1);
    a_hold = 1'b0;
    cyc(6);
    do_tick(16'h0);
    play = 1'b0;
    cyc(6);
    chk("ovr_out_count", 32'(a_out.size()), 32'd4);
    chk("ovr_out0", (a_out.size() > 0) ? 32'(a_out[0]) : 32'hFFFF_FFFF, 32'h1);
    chk("ovr_out1_repeat", (a_out.size() > 1) ? 32'(a_out[1]) : 32'hFFFF_FFFF, 32'h1);
    chk("ovr_out2", (a_out.size() > 2) ? 32'(a_out[2]) : 32'hFFFF_FFFF, 32'h2);
    chk("ovr_out3", (a_out.size() > 3) ? 32'(a_out[3]) : 32'hFFFF_FFFF, 32'h3);
    chk("ovr_reads", 32'(a_rd_cnt), 32'd3);
    chk("ovr_rd_ptr", 32'(dut_a.rd_ptr), 32'd3);

    // Both enables and both loads together: loads clear, RECORD wins.
    rec = 1'b1;
    play = 1'b1;
    wl = 1'b1;
    rl = 1'b1;
    cyc(6);
    chk("both_rec_len", 32'(a_len), 32'h0);
    chk("both_wr_ptr", 32'(dut_a.wr_ptr), 32'h0);
    chk("both_rd_ptr", 32'(dut_a.rd_ptr), 32'h0);
    chk("both_b_full_cleared", 32'(b_full), 32'h0);
    a_hold = 1'b1;
    tick = 1'b1;
    sin = 16'hBEEF;
    cyc(1);
    tick = 1'b0;
    cyc(1);
    chk("both_req", 32'(a_req), 32'h1);
    chk("both_we", 32'(a_we), 32'h1);
    chk("both_addr", 32'(a_addr), 32'(BASE_A));
    chk("both_wdata", 32'(a_wdata), 32'hBEEF);

    // Asynchronous reset while the request is outstanding.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(a_req), 32'h0);
    cyc(3);
    rst_n = 1'b1;
    a_hold = 1'b0;
    cyc(8);
    chk("post_rst_req", 32'(a_req), 32'h0);
    chk("post_rst_writes", 32'(a_wlog.size()), 32'd8);
    chk("post_rst_overrun", 32'(a_ovr), 32'h0);
    chk("post_rst_rec_len", 32'(a_len), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_rec_play_ctrl.md
# audio_rec_play_ctrl

Consumer of the key detector's record/play controls. Turns `record_en` / `play_en` / `wr_load` / `rd_load` into a sample-rate paced stream of single-word memory writes (record) and reads (playback) against the DDR user port. It owns the write pointer, read pointer and recorded length. It sits between the key detector and the codec sample interface on one side, and the DDR arbiter on the other.

## Interface
Parameters:
- ADDR_W, 24, memory word-address width
- DATA_W, 16, sample / memory word width
- BASE_ADDR, 0, first word address of the audio buffer
- MAX_WORDS, 24'h100000, buffer capacity in words (≥2)

Ports:
- clk50M  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ddr_init_done  in  1  DDR calibrated; level, may be asynchronous
- record_en, play_en, wr_load, rd_load  in  1 each  controls from the key detector; slow-clock domain, treated as asynchronous
- sample_tick  in  1  one-cycle pulse per codec sample period
- sample_in  in  DATA_W  ADC sample, valid on sample_tick
- sample_out  out  DATA_W  DAC sample
- sample_out_valid  out  1  one-cycle pulse when sample_out updates
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; stable while mem_req
- mem_addr  out  ADDR_W  word address; stable while mem_req
- mem_wdata  out  DATA_W  write data; stable while mem_req
- mem_ack  in  1  one-cycle accept; read data valid in the same cycle
- mem_rdata  in  DATA_W  read data
- rec_len  out  ADDR_W  number of words recorded
- buf_full  out  1  capacity reached during record
- overrun  out  1  sticky: a sample_tick found a request still outstanding

## Operation
- Input synchronisation:
  - Two-flop synchroniser on each of ddr_init_done, record_en, play_en, wr_load, rd_load.
  - Rising-edge detect on synchronised wr_load and rd_load produces internal one-cycle pulses.
- States: INIT, IDLE, RECORD, PLAY.
  - INIT: stay until synced ddr_init_done = 1, then go to IDLE. No memory requests are issued in INIT.
  - IDLE to RECORD: when synced record_en = 1.
  - IDLE to PLAY: when synced play_en = 1. If record_en and play_en are both high, RECORD wins.
  - RECORD or PLAY to IDLE: when the respective enable drops. An outstanding request is always completed (mem_req held until mem_ack) before the state leaves RECORD or PLAY.
- Pointer loads (pulses from rising edges; honoured in any state except INIT):
  - wr_load: wr_ptr←0, rec_len←0, buf_full←0.
  - rd_load: rd_ptr←0.
  - Both in the same cycle: both actions apply.
  - If a load coincides with an outstanding request, the request completes normally and the load takes effect on its own cycle. The load has priority over any pointer increment in that cycle.
- RECORD:
  - On sample_tick with no request outstanding and buf_full = 0: issue a write with mem_addr = BASE_ADDR + wr_ptr and mem_wdata = sample_in.
  - On mem_ack: wr_ptr and rec_len increment. When rec_len reaches MAX_WORDS, buf_full←1.
  - While buf_full = 1, samples are discarded. There is no wrap.
- PLAY:
  - On sample_tick with no request outstanding:
    - If rd_ptr < rec_len: issue a read at BASE_ADDR + rd_ptr.
    - Otherwise: sample_out←0 with sample_out_valid pulse, and no memory request.
  - On the read's mem_ack: sample_out←mem_rdata, sample_out_valid pulse, rd_ptr increments.
- Overrun: a sample_tick while mem_req = 1 sets overrun (sticky until reset).
  - In RECORD, that sample is dropped.
  - In PLAY, sample_out repeats its previous value with a sample_out_valid pulse.
- Arithmetic: pointers are ADDR_W unsigned. BASE_ADDR + ptr wraps modulo 2^ADDR_W.

## Timing
- Reset values: sample_out = 0, sample_out_valid = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rec_len = 0, buf_full = 0, overrun = 0. State = INIT, wr_ptr = 0, rd_ptr = 0.
- Control latency: 2 cycles of synchroniser, plus 1 cycle to the state change.
- Request timing: mem_req rises in the cycle after sample_tick.
  - mem_ack may arrive from the cycle mem_req is high onward, at arbitrary delay.
  - mem_req falls in the cycle after mem_ack.
  - A new request is not issued earlier than the cycle after mem_req falls.
- Read data: sample_out and sample_out_valid are registered, appearing 1 cycle after the mem_ack that carries the data.
- Silence and repeated samples: output 1 cycle after sample_tick.
- Reset mid-operation: asynchronous. mem_req drops immediately, and no pending ack is honoured after release.

## Test plan
- Reset, then ddr_init_done held 0 while record_en = 1 and 10 sample_ticks -> mem_req stays 0, state INIT.
- Init done, wr_load pulse, then record_en with 8 ticks of samples 0x0001..0x0008, ack 3 cycles after each req -> 8 writes at addresses BASE+0..7 with matching data; rec_len = 8.
- rd_load, then play_en for 10 ticks -> sample_out 0x0001..0x0008, then 0x0000 twice; exactly 8 reads issued.
- MAX_WORDS = 4, record 6 ticks -> 4 writes, buf_full = 1 after the 4th ack, ticks 5 and 6 produce no request.
- mem_ack withheld across two sample_ticks in PLAY -> overrun = 1 and sample_out repeats its previous value; pointer advances only once.
- record_en and play_en asserted together, and wr_load and rd_load pulsed together -> RECORD is entered, wr_ptr = rd_ptr = rec_len = 0; deassert reset_n mid-request -> mem_req = 0 asynchronously.
